// File: rtl/fetch_stage_queued_pkg.sv
// Shared fetch/decode types and constants.
// XLEN, the fetch NOP and the {pc, instr} queue entry.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_queued_if.sv
// Fetch-to-decode handshake bundle.
// The fetch side drives the head entry; decode drives ready.
interface fetch_stage_queued_if
    import riscv_pkg::*;
();

    logic            dec_valid_o;
    logic            dec_ready_i;
    logic [31:0]     instr_d_o;
    logic [XLEN-1:0] pc_d_o;

    modport master (
        output dec_valid_o,
        output instr_d_o,
        output pc_d_o,
        input  dec_ready_i
    );

    modport slave (
        input  dec_valid_o,
        input  instr_d_o,
        input  pc_d_o,
        output dec_ready_i
    );

endinterface

// File: rtl/fetch_stage_queued_queue.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// DEPTH must be a power of two so pointers wrap naturally.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_stage_queued.sv
// IF stage: PC register, next-PC mux and prefetch queue
// feeding decode over a valid/ready handshake.
module fetch_stage_queued
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = NOP_INSTR,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [XLEN-1:0]       redirect_pc_i,
    output logic [XLEN-1:0]       imem_addr_o,
    input  logic [31:0]           imem_rdata_i,
    output logic [CW-1:0]         fq_count_o,
    fetch_stage_queued_if.master  dec
);

    logic [XLEN-1:0] pc_q, pc_d;
    fetch_entry_t    wr_ent;
    fetch_entry_t    hd_ent;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;

    assign pop  = dec.dec_valid_o & dec.dec_ready_i;
    assign push = ~redirect_i & (~full | pop);

    assign wr_ent.pc    = pc_q;
    assign wr_ent.instr = imem_rdata_i;

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            redirect_i: pc_d = redirect_pc_i & ~XLEN'(3);
            push:       pc_d = pc_q + XLEN'(4);
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fq (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i (wr_ent),
        .rdata_o (hd_ent),
        .count_o (fq_count_o),
        .empty_o (empty),
        .full_o  (full)
    );

    assign imem_addr_o     = pc_q;
    assign dec.dec_valid_o = ~empty;
    assign dec.instr_d_o   = empty ? NOP : hd_ent.instr;
    assign dec.pc_d_o      = empty ? '0 : hd_ent.pc;

endmodule

// File: tb/tb_fetch_stage_queued.sv
// Scoreboard bench for fetch_stage_queued: a queue model
// predicts occupancy, PC and committed entries.
module tb_fetch_stage_queued;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC  = 32'h0;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        bit          chk;
        int          cnt;
        logic [31:0] addr;
        bit          valid;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [2:0]  fq_count;

    logic        rst2 = 1'b1;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic [2:0]  fq_count2;

    int vecs = 0;
    int errs = 0;

    ent_t mq[$];
    ent_t exp_q[$];
    cyc_t cyc_q[$];
    logic [31:0] mpc = '0;
    bit known = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_rdata  = imem_f(imem_addr);
    assign imem_rdata2 = imem_f(imem_addr2);

    fetch_stage_queued_if dif ();
    fetch_stage_queued_if dif2 ();

    fetch_stage_queued #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .fq_count_o    (fq_count),
        .dec           (dif)
    );

    fetch_stage_queued #(
        .DEPTH    (DEPTH),
        .RESET_PC (WRAP_PC)
    ) dut_wrap (
        .clk           (clk),
        .rst           (rst2),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .imem_addr_o   (imem_addr2),
        .imem_rdata_i  (imem_rdata2),
        .fq_count_o    (fq_count2),
        .dec           (dif2)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances to the post-edge state.
    task automatic step(input logic r, input logic rdy,
                        input logic rd, input logic [31:0] tgt);
        cyc_t c;
        ent_t e;
        bit mvalid, commit, mpush;
        rst = r;
        dif.dec_ready_i = rdy;
        redirect = rd;
        redirect_pc = tgt;
        mvalid  = (mq.size() != 0);
        c.chk   = known;
        c.cnt   = mq.size();
        c.addr  = mpc;
        c.valid = mvalid;
        cyc_q.push_back(c);
        commit = mvalid && rdy && !rd && !r;
        if (commit) exp_q.push_back(mq[0]);
        if (r) begin
            mq.delete();
            mpc = RST_PC;
            known = 1;
        end else if (rd) begin
            mq.delete();
            mpc = tgt & ~32'h3;
        end else begin
            mpush = (mq.size() < DEPTH) || commit;
            if (commit) void'(mq.pop_front());
            if (mpush) begin
                e.pc    = mpc;
                e.instr = imem_f(mpc);
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        cyc_t c;
        ent_t e;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            if (c.chk) begin
                chk("count", 32'(fq_count), 32'(c.cnt));
                chk("imem_addr", imem_addr, c.addr);
                chk("valid", 32'(dif.dec_valid_o), 32'(c.valid));
                if (!c.valid) begin
                    chk("nop_instr", dif.instr_d_o, 32'h13);
                    chk("nop_pc", dif.pc_d_o, 32'h0);
                end
                if (dif.dec_valid_o === 1'b1 &&
                    dif.dec_ready_i && !redirect && !rst) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_commit", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_pc", dif.pc_d_o, e.pc);
                        chk("commit_instr", dif.instr_d_o, e.instr);
                    end
                end
            end
        end
    end

    initial begin
        dif.dec_ready_i  = 1'b0;
        dif2.dec_ready_i = 1'b0;
        @(posedge clk);
        #1;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_count", 32'(fq_count), 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(dif.dec_valid_o), 32'h0);
        chk("rst_instr", dif.instr_d_o, 32'h13);
        chk("rst_pc", dif.pc_d_o, 32'h0);

        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("bp_count", 32'(fq_count), 32'd4);
        chk("bp_addr", imem_addr, 32'h10);
        step(0, 1, 0, 0);
        chk("bp_pop_count", 32'(fq_count), 32'd4);
        chk("bp_pop_addr", imem_addr, 32'h14);

        step(0, 0, 1, 32'h103);
        chk("redir_count", 32'(fq_count), 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        step(0, 1, 0, 0);
        chk("redir_valid", 32'(dif.dec_valid_o), 32'h1);
        chk("redir_pc", dif.pc_d_o, 32'h100);

        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("mid_count", 32'(fq_count), 32'd3);
        step(1, 0, 1, 32'h200);
        chk("mid_rst_count", 32'(fq_count), 32'd0);
        chk("mid_rst_addr", imem_addr, RST_PC);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom);
        end
        step(0, 0, 0, 0);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        rst2 = 1'b0;
        dif2.dec_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap_pc0", dif2.pc_d_o, 32'hFFFF_FFF8);
        chk("wrap_instr0", dif2.instr_d_o, imem_f(32'hFFFF_FFF8));
        @(posedge clk);
        #1;
        chk("wrap_pc1", dif2.pc_d_o, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        chk("wrap_pc2", dif2.pc_d_o, 32'h0);
        chk("wrap_addr", imem_addr2, 32'h4);
        chk("wrap_count", 32'(fq_count2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
